// File: rtl/rx_data_unstuff.sv
// Receive-side bit unstuffer for DATA0 payloads: strips stuffed bits, collects 64 payload + 16 CRC bits, then flags the packet good or bad.
// Optional macro RX_CRC_CHECK_EN adds the CRC16 register and residual check; without it only the stuff and length checks apply.
module rx_data_unstuff (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_bit,
  input  logic        bit_valid,
  input  logic        load_data,
  output logic [63:0] data_out,
  output logic        data_valid,
  output logic        pkt_err,
  output logic [1:0]  err_code,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  localparam logic [6:0] FULL_COUNT = 7'd80;
  localparam logic [6:0] MAX_COUNT  = 7'd81;
`ifdef RX_CRC_CHECK_EN
  localparam logic [15:0] CRC_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC_POLY     = 16'h8005;
  localparam logic [15:0] CRC_RESIDUAL = 16'h800D;
`endif

  state_t      state, state_next;
  logic        take_bit, finish, abort, pkt_good;
  logic [1:0]  err_next;
  logic [2:0]  ones_cnt, ones_base, ones_next;
  logic [6:0]  bit_cnt, bit_base, bit_next;
  logic        stuff_err, stuff_base, stuff_next;
  logic [79:0] shift_reg, shift_next;
`ifdef RX_CRC_CHECK_EN
  logic [15:0] crc, crc_base, crc_next;
  logic        crc_fb;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // load_data wins over bit_valid; a gap with neither strobe aborts the packet
  always_comb begin
    state_next = state;
    take_bit   = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (bit_valid) begin
          state_next = RECV;
          take_bit   = 1'b1;
        end
      end
      RECV: begin
        if (load_data) begin
          state_next = CHECK;
          finish     = 1'b1;
        end else if (bit_valid) begin
          take_bit = 1'b1;
        end else begin
          state_next = IDLE;
          abort      = 1'b1;
        end
      end
      CHECK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The first bit of a packet is accumulated on top of freshly cleared counters
  always_comb begin
    ones_base  = (state == IDLE) ? 3'd0 : ones_cnt;
    bit_base   = (state == IDLE) ? 7'd0 : bit_cnt;
    stuff_base = (state == IDLE) ? 1'b0 : stuff_err;
    ones_next  = ones_cnt;
    bit_next   = bit_cnt;
    stuff_next = stuff_err;
    shift_next = shift_reg;
`ifdef RX_CRC_CHECK_EN
    crc_base   = (state == IDLE) ? CRC_INIT : crc;
    crc_next   = crc;
    crc_fb     = in_bit ^ crc_base[15];
`endif
    if (take_bit) begin
      ones_next  = ones_base;
      bit_next   = bit_base;
      stuff_next = stuff_base;
`ifdef RX_CRC_CHECK_EN
      crc_next   = crc_base;
`endif
      if (ones_base == 3'd6) begin
        ones_next = 3'd0;
        if (in_bit) stuff_next = 1'b1;
      end else begin
        ones_next  = in_bit ? (ones_base + 3'd1) : 3'd0;
        shift_next = {in_bit, shift_reg[79:1]};
        if (bit_base != MAX_COUNT) bit_next = bit_base + 7'd1;
`ifdef RX_CRC_CHECK_EN
        crc_next = {crc_base[14:0], 1'b0} ^ (crc_fb ? CRC_POLY : 16'h0000);
`endif
      end
    end
  end

  always_comb begin
    err_next = 2'b00;
    pkt_good = 1'b0;
    if (stuff_err)                 err_next = 2'b01;
    else if (bit_cnt != FULL_COUNT) err_next = 2'b10;
`ifdef RX_CRC_CHECK_EN
    else if (crc != CRC_RESIDUAL)   err_next = 2'b11;
`endif
    else                           pkt_good = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ones_cnt  <= 3'd0;
      bit_cnt   <= 7'd0;
      stuff_err <= 1'b0;
      shift_reg <= 80'd0;
`ifdef RX_CRC_CHECK_EN
      crc       <= CRC_INIT;
`endif
    end else begin
      ones_cnt  <= ones_next;
      bit_cnt   <= bit_next;
      stuff_err <= stuff_next;
      shift_reg <= shift_next;
`ifdef RX_CRC_CHECK_EN
      crc       <= crc_next;
`endif
    end
  end

  // Verdict is registered on the load_data edge so the pulse lands in the CHECK cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_out   <= 64'd0;
      data_valid <= 1'b0;
      pkt_err    <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      data_valid <= 1'b0;
      pkt_err    <= 1'b0;
      if (finish) begin
        if (pkt_good) begin
          data_valid <= 1'b1;
          data_out   <= shift_reg[63:0];
        end else begin
          pkt_err  <= 1'b1;
          err_code <= err_next;
        end
      end else if (abort) begin
        pkt_err  <= 1'b1;
        err_code <= 2'b10;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_rx_data_unstuff.sv
// Self-checking bench for rx_data_unstuff: table of packets plus hand-written abort, reset and idle sequences.
// Expected verdicts go into a scoreboard queue when load_data (or a gap) is driven and are popped when a pulse appears.
module tb_rx_data_unstuff;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_bit = 1'b0;
  logic        bit_valid = 1'b0;
  logic        load_data = 1'b0;
  logic [63:0] data_out;
  logic        data_valid;
  logic        pkt_err;
  logic [1:0]  err_code;
  logic        busy;

  rx_data_unstuff dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_bit     (in_bit),
    .bit_valid  (bit_valid),
    .load_data  (load_data),
    .data_out   (data_out),
    .data_valid (data_valid),
    .pkt_err    (pkt_err),
    .err_code   (err_code),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  localparam int MODE_GOOD     = 0;
  localparam int MODE_CRC_FLIP = 1;
  localparam int MODE_NO_STUFF = 2;
  localparam int MODE_SHORT    = 3;
  localparam int NUM_VECS      = 7;

  typedef struct {
    logic [63:0] payload;
    int          mode;
    logic        exp_good;
    logic [1:0]  exp_code;
  } vec_t;

  typedef struct {
    int          cyc;
    logic        good;
    logic [63:0] dout;
    logic [1:0]  code;
    int          id;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  vec_t        vecs[NUM_VECS];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cycle = 0;
  logic [63:0] model_dout = 64'd0;
  logic [1:0]  model_err = 2'b00;
  logic [79:0] stream;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic logic [15:0] crc16_model(input logic [63:0] p);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < 64; i++) begin
      fb = p[i] ^ c[15];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end
    return c;
  endfunction

  // Transmit order: payload LSB first, then the inverted CRC from bit 15 down to bit 0
  function automatic logic [79:0] build_stream(input logic [63:0] p, input logic flip_crc0);
    logic [15:0] c;
    logic [79:0] s;
    c = crc16_model(p);
    s[63:0] = p;
    for (int j = 0; j < 16; j++) s[64 + j] = ~c[15 - j];
    if (flip_crc0) s[79] = ~s[79];
    return s;
  endfunction

  task automatic send_bits(input logic [79:0] s, input int n, input logic do_stuff);
    int ones;
    ones = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      in_bit    = s[i];
      bit_valid = 1'b1;
      load_data = 1'b0;
      if (do_stuff) begin
        ones = s[i] ? ones + 1 : 0;
        if (ones == 6) begin
          @(negedge clock);
          in_bit = 1'b0;
          ones   = 0;
        end
      end
    end
  endtask

  task automatic push_expect(input logic good, input logic [1:0] code, input logic [63:0] payload, input int id);
    exp_t e;
    if (good) model_dout = payload;
    else      model_err  = code;
    e.cyc  = cycle + 1;
    e.good = good;
    e.dout = model_dout;
    e.code = model_err;
    e.id   = id;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input vec_t v, input int id);
    logic [79:0] s;
    s = build_stream(v.payload, v.mode == MODE_CRC_FLIP);
    send_bits(s, (v.mode == MODE_SHORT) ? 79 : 80, v.mode != MODE_NO_STUFF);
    @(negedge clock);
    bit_valid = 1'b0;
    in_bit    = 1'b0;
    load_data = 1'b1;
    push_expect(v.exp_good, v.exp_code, v.payload, id);
    @(negedge clock);
    load_data = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  always @(posedge clock) begin
    #1;
    cycle++;
    if (data_valid || pkt_err) begin
      checkOutput("pulse_exclusive", 64'(data_valid & pkt_err), 64'd0);
      checkOutput("pulse_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        $display("[TB] pulse for packet %0d at cycle %0d", mon_e.id, cycle);
        checkOutput("pulse_cycle", 64'(cycle), 64'(mon_e.cyc));
        checkOutput("data_valid", 64'(data_valid), 64'(mon_e.good));
        checkOutput("pkt_err", 64'(pkt_err), 64'(!mon_e.good));
        checkOutput("data_out", data_out, mon_e.dout);
        checkOutput("err_code", 64'(err_code), 64'(mon_e.code));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{64'h0123_4567_89AB_CDEF, MODE_GOOD,     1'b1, 2'b00};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, MODE_GOOD,     1'b1, 2'b00};
`ifdef RX_CRC_CHECK_EN
    vecs[2] = '{64'h0123_4567_89AB_CDEF, MODE_CRC_FLIP, 1'b0, 2'b11};
`else
    vecs[2] = '{64'h0123_4567_89AB_CDEF, MODE_CRC_FLIP, 1'b1, 2'b00};
`endif
    vecs[3] = '{64'h0000_0000_0000_007F, MODE_NO_STUFF, 1'b0, 2'b01};
    vecs[4] = '{64'hA5A5_A5A5_A5A5_A5A5, MODE_SHORT,    1'b0, 2'b10};
    vecs[5] = '{64'h0000_0000_0000_0000, MODE_GOOD,     1'b1, 2'b00};
    vecs[6] = '{64'hDEAD_BEEF_CAFE_F00D, MODE_GOOD,     1'b1, 2'b00};

    repeat (3) @(negedge clock);
    checkOutput("reset_data_out", data_out, 64'd0);
    checkOutput("reset_data_valid", 64'(data_valid), 64'd0);
    checkOutput("reset_pkt_err", 64'(pkt_err), 64'd0);
    checkOutput("reset_err_code", 64'(err_code), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // A stray end-of-packet strobe while idle must not produce a pulse
    load_data = 1'b1;
    @(negedge clock);
    load_data = 1'b0;
    checkOutput("idle_load_busy", 64'(busy), 64'd0);
    checkOutput("idle_load_pulse", 64'(data_valid | pkt_err), 64'd0);
    repeat (2) @(negedge clock);

    for (int i = 0; i < NUM_VECS; i++) applyStimulus(vecs[i], i);

    // Gap in bit_valid mid-packet aborts with a length error on the next edge
    stream = build_stream(64'h0123_4567_89AB_CDEF, 1'b0);
    send_bits(stream, 30, 1'b1);
    @(negedge clock);
    bit_valid = 1'b0;
    in_bit    = 1'b0;
    push_expect(1'b0, 2'b10, 64'd0, 100);
    @(negedge clock);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clock);

    // Asynchronous reset in the middle of a packet
    send_bits(stream, 40, 1'b1);
    @(posedge clock);
    #2;
    reset_n   = 1'b0;
    bit_valid = 1'b0;
    in_bit    = 1'b0;
    model_dout = 64'd0;
    model_err  = 2'b00;
    #1;
    checkOutput("midreset_busy", 64'(busy), 64'd0);
    checkOutput("midreset_pulse", 64'(data_valid | pkt_err), 64'd0);
    checkOutput("midreset_data_out", data_out, 64'd0);
    checkOutput("midreset_err_code", 64'(err_code), 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checkOutput("post_reset_busy", 64'(busy), 64'd0);
    applyStimulus(vecs[0], 200);

    repeat (5) @(negedge clock);
    checkOutput("pending_pulses", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_data_unstuff.md
RX_DATA_UNSTUFF -- requirements
Module: rx_data_unstuff

Interface
- REQ-001: The module SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
- REQ-002: The module SHALL have port reset_n, input, 1, asynchronous active-low reset.
- REQ-003: The module SHALL have port in_bit, input, 1, decoded serial line bit from the DP/DM decoder.
- REQ-004: The module SHALL have port bit_valid, input, 1, high on each cycle in_bit carries a DATA0 packet bit; driven by the decoder's dpdm_sending.
- REQ-005: The module SHALL have port load_data, input, 1, one-cycle end-of-packet pulse from the decoder.
- REQ-006: The module SHALL have port data_out, output, 64, received payload, first de-stuffed bit in data_out[0].
- REQ-007: The module SHALL have port data_valid, output, 1, one-cycle pulse meaning the packet was good and data_out is valid.
- REQ-008: The module SHALL have port pkt_err, output, 1, one-cycle pulse meaning the packet was bad.
- REQ-009: The module SHALL have port err_code, output, 2, error cause (01 stuff, 10 length, 11 CRC), valid with pkt_err.
- REQ-010: The module SHALL have port busy, output, 1, high while in RECV or CHECK.

Function
- REQ-011: The FSM SHALL have the states IDLE, RECV and CHECK.
- REQ-012: IDLE SHALL go to RECV on the first cycle with bit_valid=1, and that cycle's bit SHALL be processed.
- REQ-013: RECV SHALL process one bit per bit_valid cycle; a load_data pulse SHALL go to CHECK and SHALL NOT sample a bit.
- REQ-014: If bit_valid and load_data are both high, load_data SHALL take priority.
- REQ-015: In RECV, a cycle with bit_valid=0 and load_data=0 SHALL abort: pkt_err=1, err_code=10, next state IDLE.
- REQ-016: Bit unstuffing SHALL use a 3-bit ones counter; each 1 increments it and each 0 clears it.
- REQ-017: The bit that follows six consecutive 1s SHALL be discarded and the counter cleared.
- REQ-018: If the discarded bit is 1, the stuff_err flag SHALL be set and SHALL stay set until IDLE.
- REQ-019: Each de-stuffed bit SHALL enter an 80-bit right-shift register (64 payload + 16 CRC) at the MSB end.
- REQ-020: A 7-bit bit counter SHALL count de-stuffed bits and saturate at 81.
- REQ-021: CRC16 SHALL operate as follows: init 16'hFFFF; per de-stuffed bit fb = bit ^ crc[15]; crc = {crc[14:0],1'b0} ^ (fb ? 16'h8005 : 0).
- REQ-022: In CHECK (exactly one cycle, then IDLE), error priority SHALL be stuff (01) > count != 80 (10) > crc != 16'h800D (11).
- REQ-023: On a good packet CHECK SHALL assert data_valid and load data_out with shift[63:0]; otherwise it SHALL assert pkt_err and err_code.
- REQ-024: Latency SHALL be exactly one clock from the load_data sample to the data_valid or pkt_err pulse.
- REQ-025: data_valid and pkt_err SHALL never both be high.
- REQ-026: data_out SHALL hold its value until the next good packet.
- REQ-027: err_code SHALL hold its value until the next error.
- REQ-028: Entering RECV SHALL clear the ones counter, bit counter and stuff_err, and SHALL reload CRC with 16'hFFFF.
- REQ-029: load_data in IDLE SHALL be ignored, with no pulse.

Reset
- REQ-030: reset_n=0 SHALL asynchronously force IDLE at any time, including mid-packet, with no pulse emitted.
- REQ-031: Reset SHALL set data_out=0, data_valid=0, pkt_err=0, err_code=00, busy=0 and CRC=16'hFFFF, and clear all counters and the shift register.

Configuration
- REQ-032: The macro RX_CRC_CHECK_EN SHALL control the CRC check: when defined, the CRC16 register and the CRC check are present.
- REQ-033: When RX_CRC_CHECK_EN is undefined, the CRC register SHALL be absent, err_code 11 SHALL never occur, and the stuff and length checks SHALL still apply.

Verification
- REQ-034: Bench SHALL send payload 64'h0123_4567_89AB_CDEF with correct CRC (bench model), stuffed, then load_data -> one cycle later data_valid=1, data_out=64'h0123_4567_89AB_CDEF, pkt_err=0.
- REQ-035: Bench SHALL send payload 64'hFFFF_FFFF_FFFF_FFFF with correct CRC (10 stuffed zeros inserted in payload) -> data_valid=1, data_out all ones.
- REQ-036: Bench SHALL send a good packet with CRC bit 0 flipped -> pkt_err=1, err_code=11, data_out unchanged from previous packet.
- REQ-037: Bench SHALL send seven consecutive 1s inside the payload -> at CHECK pkt_err=1, err_code=01.
- REQ-038: Bench SHALL send 79 de-stuffed bits then load_data -> pkt_err=1, err_code=10; and bit_valid dropped for one cycle mid-packet without load_data -> immediate pkt_err, err_code=10, back to IDLE.
- REQ-039: Bench SHALL pulse reset_n low after 40 bits -> busy=0 immediately, no pulses; the next good packet -> data_valid=1 with correct data.
